// File: rtl/riscv_pkg.sv
// Shared RV32I controller definitions: ALU operation codes (also used by the
// ALU), opcode values, controller state encoding, immediate formats and the
// datapath select encodings driven by control_fsm.
package riscv_pkg;

    // ALU operation code, shared with the ALU.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_ctrl_e;

    // Major opcodes.
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Controller states.
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_JALR, S_JAL,
        S_LUI, S_AUIPC, S_TRAP
    } state_e;

    // Immediate formats.
    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    // Result select.
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU A select.
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    // ALU B select.
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // How the ALU operation is chosen in the current state.
    typedef enum logic [1:0] {
        ALUC_ADD,
        ALUC_FUNCT,
        ALUC_BRANCH
    } alu_class_e;

    // Immediate format depends on the opcode only.
    function automatic imm_src_e imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:         return IMM_S;
            OP_BRANCH:        return IMM_B;
            OP_JAL:           return IMM_J;
            OP_LUI, OP_AUIPC: return IMM_U;
            default:          return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/control_fsm_alu_decoder.sv
// alu_decoder: combinational ALU operation selection.
//   cls_i         - how the current state uses the ALU (fixed add, funct, branch)
//   funct3_i      - instruction[14:12]
//   funct7b5_i    - instruction[30]
//   op5_i         - opcode bit 5; 1 = R-type, 0 = I-type ALU
//   alu_control_o - ALU operation code
module alu_decoder
    import riscv_pkg::*;
(
    input  alu_class_e  cls_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic        op5_i,
    output alu_ctrl_e   alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (cls_i)
            ALUC_FUNCT: begin
                case (funct3_i)
                    // funct7b5 of an I-type is immediate bit 10, so only R-type subtracts
                    3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control_o = ALU_SLL;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b011:  alu_control_o = ALU_SLTU;
                    3'b100:  alu_control_o = ALU_XOR;
                    3'b101:  alu_control_o = funct7b5_i ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control_o = ALU_OR;
                    default: alu_control_o = ALU_AND;
                endcase
            end
            ALUC_BRANCH: begin
                case (funct3_i[2:1])
                    2'b00:   alu_control_o = ALU_SUB;
                    2'b10:   alu_control_o = ALU_SLT;
                    2'b11:   alu_control_o = ALU_SLTU;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// control_fsm: multicycle RV32I main controller (Moore FSM).
//   clk, rst_n              - clock, asynchronous active-low reset
//   op, funct3, funct7b5    - latched instruction fields
//   Zero                    - ALU zero flag (branch resolution)
//   mem_ready               - memory access completes this cycle
//   PCWrite, IRWrite, MemWrite, RegWrite - write enables
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc - datapath selects
//   ALU_control             - ALU operation code
//   illegal                 - sticky trap indicator (held until reset)
module control_fsm
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALU_control,
    output logic       illegal
);

    state_e     state_q, state_d;
    alu_class_e alu_class;
    alu_ctrl_e  alu_ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_BRANCH:         state_d = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_TRAP;
                endcase
            end
            // only loads and stores reach MEMADR; op[5] separates them
            S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            // JALR computes the target, then shares JAL's link/PC-update path
            S_JALR:     state_d = S_JAL;
            S_JAL:      state_d = S_ALUWB;
            S_LUI:      state_d = S_ALUWB;
            S_AUIPC:    state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
    end

    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        alu_class = ALUC_ADD;
        illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_RS2;
                alu_class = ALUC_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                alu_class = ALUC_FUNCT;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_RS2;
                alu_class = ALUC_BRANCH;
                // funct3[0] inverts the sense; the compare-based branches
                // (funct3[2]) take on a nonzero SLT/SLTU result
                PCWrite   = Zero ^ funct3[0] ^ funct3[2];
            end
            S_JALR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
            S_LUI: begin
                ALUSrcA = SRCA_ZERO;
                ALUSrcB = SRCB_IMM;
            end
            S_AUIPC: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_TRAP:  illegal = 1'b1;
            default: illegal = 1'b1;
        endcase
        // state is already FETCH during reset; this only masks the enables
        if (!rst_n) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

    alu_decoder u_alu_decoder (
        .cls_i         (alu_class),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .op5_i         (op[5]),
        .alu_control_o (alu_ctrl)
    );

    assign ALU_control = alu_ctrl;
    assign ImmSrc      = imm_src_of(op);

endmodule

// File: tb/tb_control_fsm.sv
// Testbench for control_fsm: each instruction is expanded into the list of
// phases it should pass through, and each cycle's outputs are compared with a
// table of what that phase must drive.
module tb_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALU_control;

    control_fsm dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALU_control(ALU_control), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    typedef enum int {
        P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE, P_EXECR,
        P_EXECI, P_ALUWB, P_BRANCH, P_JALR, P_JAL, P_LUI, P_AUIPC, P_TRAP
    } phase_t;

    // {PCWrite,AdrSrc,IRWrite,MemWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALU_control,illegal}
    wire [18:0] got_vec = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
                           ALUSrcA, ALUSrcB, ImmSrc, ALU_control, illegal};

    function automatic logic [2:0] imm_ref(input logic [6:0] o);
        if (o == 7'b0100011) return 3'd1;
        if (o == 7'b1100011) return 3'd2;
        if (o == 7'b1101111) return 3'd3;
        if (o == 7'b0110111 || o == 7'b0010111) return 3'd4;
        return 3'd0;
    endfunction

    // ALU op for register/immediate arithmetic; rtype selects the subtract rule
    function automatic logic [3:0] arith_ref(input logic [2:0] f3, input logic f7, input bit rtype);
        logic [3:0] tbl [8];
        tbl = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        if (f3 == 3'd0 && rtype && f7) return 4'd1;
        if (f3 == 3'd5 && f7) return 4'd9;
        return tbl[f3];
    endfunction

    function automatic logic [18:0] exp_vec(input phase_t p, input logic [6:0] o,
                                            input logic [2:0] f3, input logic f7,
                                            input logic z, input logic rdy);
        logic pcw = 0, adr = 0, irw = 0, mw = 0, rw = 0, ill = 0;
        logic [1:0] res = 0, a = 0, b = 0;
        logic [3:0] alu = 0;
        case (p)
            P_FETCH:    begin b = 2; res = 2; irw = rdy; pcw = rdy; end
            P_DECODE:   begin a = 1; b = 1; end
            P_MEMADR:   begin a = 2; b = 1; end
            P_MEMREAD:  adr = 1;
            P_MEMWB:    begin res = 1; rw = 1; end
            P_MEMWRITE: begin adr = 1; mw = 1; end
            P_EXECR:    begin a = 2; b = 0; alu = arith_ref(f3, f7, 1); end
            P_EXECI:    begin a = 2; b = 1; alu = arith_ref(f3, f7, 0); end
            P_ALUWB:    rw = 1;
            P_BRANCH: begin
                a = 2; b = 0;
                alu = (f3 < 3'd2) ? 4'd1 : (f3 < 3'd6) ? 4'd5 : 4'd6;
                pcw = z ^ f3[0] ^ f3[2];
            end
            P_JALR:     begin a = 2; b = 1; end
            P_JAL:      begin a = 1; b = 2; pcw = 1; end
            P_LUI:      begin a = 3; b = 1; end
            P_AUIPC:    begin a = 1; b = 1; end
            default:    ill = 1;
        endcase
        return {pcw, adr, irw, mw, rw, res, a, b, imm_ref(o), alu, ill};
    endfunction

    // Phase list for one instruction, straight from the per-opcode sequences.
    function automatic void phases_of(input logic [6:0] o, input logic [2:0] f3,
                                      output phase_t q[$]);
        q = '{P_FETCH, P_DECODE};
        case (o)
            7'b0000011: q = {q, P_MEMADR, P_MEMREAD, P_MEMWB};
            7'b0100011: q = {q, P_MEMADR, P_MEMWRITE};
            7'b0110011: q = {q, P_EXECR, P_ALUWB};
            7'b0010011: q = {q, P_EXECI, P_ALUWB};
            7'b1100011: q.push_back((f3 == 3'd2 || f3 == 3'd3) ? P_TRAP : P_BRANCH);
            7'b1101111: q = {q, P_JAL, P_ALUWB};
            7'b1100111: q = {q, P_JALR, P_JAL, P_ALUWB};
            7'b0110111: q = {q, P_LUI, P_ALUWB};
            7'b0010111: q = {q, P_AUIPC, P_ALUWB};
            default:    q.push_back(P_TRAP);
        endcase
    endfunction

    // Called #1 after a rising edge with the controller about to be in FETCH.
    // zmode: 0/1 forces Zero, 2 randomizes. rnd randomizes wait-state stalls.
    task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input int fstall, input int mstall,
                             input int zmode, input bit rnd);
        phase_t q[$];
        phases_of(o, f3, q);
        op = o; funct3 = f3; funct7b5 = f7;
        foreach (q[i]) begin
            bit waits = (q[i] == P_FETCH || q[i] == P_MEMREAD || q[i] == P_MEMWRITE);
            int stalls = 0;
            if (q[i] == P_FETCH) stalls = fstall;
            else if (waits) stalls = mstall;
            if (rnd && waits) stalls = int'($urandom_range(0, 2));
            if (q[i] == P_TRAP) stalls = 19;
            for (int k = 0; k <= stalls; k++) begin
                mem_ready = waits ? (k == stalls) : 1'($urandom);
                Zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
                @(negedge clk);
                check($sformatf("%s/%s", name, q[i].name()), 32'(got_vec),
                      32'(exp_vec(q[i], o, f3, f7, Zero, mem_ready)));
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Asserts reset mid-cycle, checks the masked FETCH outputs, releases #1 after an edge.
    task automatic do_reset(input string name);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        check({name, "/in_reset"}, 32'(got_vec), 32'(exp_vec(P_FETCH, op, funct3, funct7b5, Zero, 1'b0)));
        @(negedge clk);
        check({name, "/in_reset_hold"}, 32'(got_vec), 32'(exp_vec(P_FETCH, op, funct3, funct7b5, Zero, 1'b0)));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [6:0] legal_ops [9];
    initial legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                          7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    initial begin
        #1;
        do_reset("por");

        // reset in the middle of DECODE of a load
        op = 7'b0000011; funct3 = 3'd2; mem_ready = 1'b1;
        @(negedge clk);
        check("rst_mid/FETCH", 32'(got_vec), 32'(exp_vec(P_FETCH, op, funct3, funct7b5, Zero, 1'b1)));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_mid/DECODE", 32'(got_vec), 32'(exp_vec(P_DECODE, op, funct3, funct7b5, Zero, 1'b1)));
        do_reset("rst_mid");

        // directed instructions
        run_instr("sub",  7'b0110011, 3'd0, 1'b1, 0, 0, 2, 0);
        run_instr("add",  7'b0110011, 3'd0, 1'b0, 0, 0, 2, 0);
        run_instr("addi", 7'b0010011, 3'd0, 1'b1, 0, 0, 2, 0);
        run_instr("srai", 7'b0010011, 3'd5, 1'b1, 0, 0, 2, 0);
        run_instr("srl",  7'b0110011, 3'd5, 1'b0, 0, 0, 2, 0);
        run_instr("beq1", 7'b1100011, 3'd0, 1'b0, 0, 0, 1, 0);
        run_instr("beq0", 7'b1100011, 3'd0, 1'b0, 0, 0, 0, 0);
        run_instr("bne1", 7'b1100011, 3'd1, 1'b0, 0, 0, 1, 0);
        run_instr("bltu0", 7'b1100011, 3'd6, 1'b0, 0, 0, 0, 0);
        run_instr("bltu1", 7'b1100011, 3'd6, 1'b0, 0, 0, 1, 0);
        run_instr("bge1", 7'b1100011, 3'd5, 1'b0, 0, 0, 1, 0);
        run_instr("lw_stall", 7'b0000011, 3'd2, 1'b0, 0, 2, 2, 0);
        run_instr("sw_stall", 7'b0100011, 3'd2, 1'b0, 1, 3, 2, 0);
        run_instr("jalr", 7'b1100111, 3'd0, 1'b1, 0, 0, 2, 0);
        run_instr("jal",  7'b1101111, 3'd5, 1'b1, 0, 0, 2, 0);
        run_instr("lui",  7'b0110111, 3'd7, 1'b1, 0, 0, 2, 0);
        run_instr("auipc", 7'b0010111, 3'd3, 1'b0, 0, 0, 2, 0);

        // illegal opcode, then illegal branch funct3; each must stick until reset
        run_instr("trap_op0", 7'b0000000, 3'd0, 1'b0, 0, 0, 2, 0);
        do_reset("trap_op0");
        run_instr("after_trap", 7'b0110011, 3'd4, 1'b0, 0, 0, 2, 0);
        run_instr("trap_br", 7'b1100011, 3'd3, 1'b0, 0, 0, 2, 0);
        do_reset("trap_br");

        // randomized legal instruction stream with random stalls
        for (int n = 0; n < 200; n++) begin
            logic [6:0] o;
            logic [2:0] f3;
            o  = legal_ops[$urandom_range(0, 8)];
            f3 = 3'($urandom);
            if (o == 7'b1100011 && f3[2:1] == 2'b01) f3[2] = 1'b1;
            run_instr("rand", o, f3, 1'($urandom), 0, 0, 2, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // absolute bound on run time
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
